hc153_scan_mux: RTL

Parametrised, registered successor to the 4:1 HC153 selector. Selects one of `CHANNELS` input words of `WIDTH` bits onto a registered output. It runs in one of two modes: direct (externally selected) or auto-scan (round-robin with a programmable dwell per channel). It sits between multi-source data buses and single-channel consumers in the cpu74hc153 datapath, and keeps the family's blanking-enable semantics.

---
 rtl/hc153_scan_mux.sv | 119 +++++++++++
 1 files changed

// File: rtl/hc153_scan_mux.sv
// Registered CHANNELS:1 word selector with direct and round-robin auto-scan modes.
// Latency: one cycle from any input to outputs; no backpressure, Enable=1 blanks output and freezes scan.
module hc153_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 4
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [CHANNELS*WIDTH-1:0] DateIn,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      Enable,
  input  logic                      Mode,
  output logic [WIDTH-1:0]          DateOut,
  output logic [SEL_W-1:0]          ChanOut,
  output logic                      Valid,
  output logic                      ScanWrap
);

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] CHAN_LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W:0]   CHAN_LIMIT = (SEL_W + 1)'(CHANNELS);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   chan, chan_nxt;
  logic [7:0]         dwell, dwell_nxt;

  logic [WIDTH-1:0]   dout_nxt;
  logic [SEL_W-1:0]   chan_out_nxt;
  logic               valid_nxt;
  logic               wrap_nxt;

  logic [SEL_W-1:0]   eff_chan;
  logic [7:0]         eff_dwell;
  logic               sel_ok;
  logic               last_dwell;
  logic [WIDTH-1:0]   sel_word;
  logic [WIDTH-1:0]   scan_word;

  // Loop mux so a non-power-of-two channel count never indexes past DateIn.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) w = bus[k*WIDTH +: WIDTH];
    end
    return w;
  endfunction

  // Entering scan from DIRECT always restarts the sweep at channel 0, dwell 0.
  assign eff_chan   = (state == ST_SCAN) ? chan  : '0;
  assign eff_dwell  = (state == ST_SCAN) ? dwell : '0;
  assign sel_ok     = ({1'b0, Sel} < CHAN_LIMIT);
  assign last_dwell = (eff_dwell == DWELL_LAST);
  assign sel_word   = pick(DateIn, Sel);
  assign scan_word  = pick(DateIn, eff_chan);

  always_comb begin
    state_nxt    = state;
    chan_nxt     = chan;
    dwell_nxt    = dwell;
    dout_nxt     = '0;
    chan_out_nxt = ChanOut;
    valid_nxt    = 1'b0;
    wrap_nxt     = 1'b0;

    if (!Enable) begin
      if (!Mode) begin
        state_nxt    = ST_DIRECT;
        chan_out_nxt = Sel;
        if (sel_ok) begin
          dout_nxt  = sel_word;
          valid_nxt = 1'b1;
        end
      end else begin
        state_nxt    = ST_SCAN;
        chan_out_nxt = eff_chan;
        dout_nxt     = scan_word;
        valid_nxt    = last_dwell;
        wrap_nxt     = last_dwell && (eff_chan == CHAN_LAST);
        if (last_dwell) begin
          dwell_nxt = '0;
          chan_nxt  = (eff_chan == CHAN_LAST) ? '0 : eff_chan + SEL_W'(1);
        end else begin
          dwell_nxt = eff_dwell + 8'd1;
          chan_nxt  = eff_chan;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_DIRECT;
      chan     <= '0;
      dwell    <= '0;
      DateOut  <= '0;
      ChanOut  <= '0;
      Valid    <= 1'b0;
      ScanWrap <= 1'b0;
    end else begin
      state    <= state_nxt;
      chan     <= chan_nxt;
      dwell    <= dwell_nxt;
      DateOut  <= dout_nxt;
      ChanOut  <= chan_out_nxt;
      Valid    <= valid_nxt;
      ScanWrap <= wrap_nxt;
    end
  end

endmodule
